sprite_engine_ctrl: RTL and testbench

Scheduler and controller for the shared 16x16 1-bit-per-channel sprite ROM in the VGA pipeline. Holds position, velocity and enable for up to NUM_SPRITES sprite instances and moves them once per frame with edge bounce. Per pixel, picks the highest-priority sprite covering the beam, drives the ROM's line/column address and registers the returned RGB. Sits between the VGA timing generator (x, y, active, frame_start) and the colour output mux.

---
 rtl/sprite_engine_ctrl_if.sv | 52 +++++
 rtl/sprite_engine_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_sprite_engine_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sprite_engine_ctrl_if.sv
// rtl/sprite_engine_ctrl_if.sv - beam, sprite config, sprite ROM and pixel output signals of the sprite engine
interface sprite_engine_ctrl_if #(
   parameter int NUM_SPRITES = 4
);
   localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

   // VGA timing generator side
   logic          frame_start;
   logic          active;
   logic [9:0]    x;
   logic [9:0]    y;

   // sprite configuration write port
   logic          cfg_we;
   logic [IW-1:0] cfg_index;
   logic          cfg_en;
   logic [9:0]    cfg_x;
   logic [9:0]    cfg_y;
   logic [3:0]    cfg_vx;
   logic [3:0]    cfg_vy;

   // shared sprite ROM
   logic [3:0]    rom_line;
   logic [3:0]    rom_column;
   logic          rom_red;
   logic          rom_green;
   logic          rom_blue;

   // colour output mux side
   logic          pixel_red;
   logic          pixel_green;
   logic          pixel_blue;
   logic          pixel_hit;
   logic          pixel_valid;
   logic          busy;

   modport master (
      output frame_start, active, x, y,
      output cfg_we, cfg_index, cfg_en, cfg_x, cfg_y, cfg_vx, cfg_vy,
      output rom_red, rom_green, rom_blue,
      input  rom_line, rom_column,
      input  pixel_red, pixel_green, pixel_blue, pixel_hit, pixel_valid, busy
   );

   modport slave (
      input  frame_start, active, x, y,
      input  cfg_we, cfg_index, cfg_en, cfg_x, cfg_y, cfg_vx, cfg_vy,
      input  rom_red, rom_green, rom_blue,
      output rom_line, rom_column,
      output pixel_red, pixel_green, pixel_blue, pixel_hit, pixel_valid, busy
   );
endinterface

// File: rtl/sprite_engine_ctrl.sv
// rtl/sprite_engine_ctrl.sv - per-frame sprite motion with edge bounce and per-pixel priority hit test driving the sprite ROM
module sprite_engine_ctrl #(
   parameter int NUM_SPRITES = 4,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480
) (
   input  logic                  clk,
   input  logic                  reset,
   sprite_engine_ctrl_if.slave   bus
);
   localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam logic [10:0] X_LIMIT = 11'(H_ACTIVE - 16);
   localparam logic [10:0] Y_LIMIT = 11'(V_ACTIVE - 16);

   typedef enum logic {IDLE, UPDATE} state_t;

   typedef struct packed {
      logic [9:0] p;
      logic [3:0] v;
   } axis_t;

   // One axis of the motion step: move, then clamp to the edge and reverse on overshoot.
   function automatic axis_t step_axis(input logic [9:0] p, input logic [3:0] v,
                                       input logic [10:0] limit);
      logic signed [10:0] n;
      logic [3:0]         neg;
      axis_t              r;
      n = $signed({1'b0, p}) + $signed({{7{v[3]}}, v});
      // -(-8) does not fit in 4 bits, so it saturates to +7
      neg = (v == 4'h8) ? 4'h7 : (~v + 4'h1);
      r.p = n[9:0];
      r.v = v;
      if (!v[3] && (v != 4'h0) && (n > $signed(limit))) begin
         r.p = limit[9:0];
         r.v = neg;
      end else if (v[3] && (n < 11'sd0)) begin
         r.p = 10'd0;
         r.v = neg;
      end
      return r;
   endfunction

   state_t        state, state_next;
   logic [IW-1:0] idx, idx_next;

   logic          en_r [NUM_SPRITES];
   logic [9:0]    sx_r [NUM_SPRITES];
   logic [9:0]    sy_r [NUM_SPRITES];
   logic [3:0]    vx_r [NUM_SPRITES];
   logic [3:0]    vy_r [NUM_SPRITES];

   axis_t         step_x, step_y;

   logic          hit;
   logic [3:0]    sel_x_lo, sel_y_lo;

   logic [3:0]    rom_line_r, rom_column_r;
   logic          hit1, valid1;
   logic          pixel_red_r, pixel_green_r, pixel_blue_r, pixel_hit_r, pixel_valid_r;

   // FSM state and sprite index register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
      end
   end

   // Next state: walk every sprite once per frame_start; pulses during the walk are dropped
   always_comb begin
      state_next = state;
      idx_next   = idx;
      case (state)
         IDLE: begin
            if (bus.frame_start) begin
               state_next = UPDATE;
               idx_next   = '0;
            end
         end
         UPDATE: begin
            if (idx == IW'(NUM_SPRITES - 1)) begin
               state_next = IDLE;
               idx_next   = '0;
            end else begin
               idx_next = idx + IW'(1);
            end
         end
         default: begin
            state_next = IDLE;
            idx_next   = '0;
         end
      endcase
   end

   // Shared motion stepper for the sprite currently selected by idx
   always_comb begin
      step_x = step_axis(sx_r[idx], vx_r[idx], X_LIMIT);
      step_y = step_axis(sy_r[idx], vy_r[idx], Y_LIMIT);
   end

   // Sprite registers: a config write beats the motion step for the same sprite
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
         if (reset) begin
            en_r[i] <= 1'b0;
            sx_r[i] <= '0;
            sy_r[i] <= '0;
            vx_r[i] <= '0;
            vy_r[i] <= '0;
         end else if (bus.cfg_we && (bus.cfg_index == IW'(i))) begin
            en_r[i] <= bus.cfg_en;
            sx_r[i] <= bus.cfg_x;
            sy_r[i] <= bus.cfg_y;
            vx_r[i] <= bus.cfg_vx;
            vy_r[i] <= bus.cfg_vy;
         end else if ((state == UPDATE) && (idx == IW'(i)) && en_r[i]) begin
            sx_r[i] <= step_x.p;
            vx_r[i] <= step_x.v;
            sy_r[i] <= step_y.p;
            vy_r[i] <= step_y.v;
         end
      end
   end

   // Hit test: descending scan so the lowest covering index is the one that sticks
   always_comb begin
      hit      = 1'b0;
      sel_x_lo = '0;
      sel_y_lo = '0;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (en_r[i] && bus.active &&
             ({1'b0, bus.x} >= {1'b0, sx_r[i]}) && ({1'b0, bus.x} < ({1'b0, sx_r[i]} + 11'd16)) &&
             ({1'b0, bus.y} >= {1'b0, sy_r[i]}) && ({1'b0, bus.y} < ({1'b0, sy_r[i]} + 11'd16))) begin
            hit      = 1'b1;
            sel_x_lo = sx_r[i][3:0];
            sel_y_lo = sy_r[i][3:0];
         end
      end
   end

   // Stage 1: ROM address inside the selected sprite, parked at 0 when nothing is hit
   always_ff @(posedge clk) begin
      if (reset) begin
         rom_line_r   <= '0;
         rom_column_r <= '0;
         hit1         <= 1'b0;
         valid1       <= 1'b0;
      end else begin
         rom_line_r   <= hit ? (bus.y[3:0] - sel_y_lo) : 4'd0;
         rom_column_r <= hit ? (bus.x[3:0] - sel_x_lo) : 4'd0;
         hit1         <= hit;
         valid1       <= bus.active;
      end
   end

   // Stage 2: register ROM colour, blanked when no sprite covers the pixel
   always_ff @(posedge clk) begin
      if (reset) begin
         pixel_red_r   <= 1'b0;
         pixel_green_r <= 1'b0;
         pixel_blue_r  <= 1'b0;
         pixel_hit_r   <= 1'b0;
         pixel_valid_r <= 1'b0;
      end else begin
         pixel_red_r   <= hit1 & bus.rom_red;
         pixel_green_r <= hit1 & bus.rom_green;
         pixel_blue_r  <= hit1 & bus.rom_blue;
         pixel_hit_r   <= hit1;
         pixel_valid_r <= valid1;
      end
   end

   assign bus.rom_line    = rom_line_r;
   assign bus.rom_column  = rom_column_r;
   assign bus.pixel_red   = pixel_red_r;
   assign bus.pixel_green = pixel_green_r;
   assign bus.pixel_blue  = pixel_blue_r;
   assign bus.pixel_hit   = pixel_hit_r;
   assign bus.pixel_valid = pixel_valid_r;
   assign bus.busy        = (state == UPDATE);
endmodule

// File: tb/tb_sprite_engine_ctrl.sv
// tb/tb_sprite_engine_ctrl.sv - directed scoreboard bench for sprite_engine_ctrl
module tb_sprite_engine_ctrl;
   localparam int NS = 4;

   typedef struct packed {
      logic       hit;
      logic       valid;
      logic [3:0] line;
      logic [3:0] col;
      logic [2:0] rgb;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb [$];

   sprite_engine_ctrl_if #(.NUM_SPRITES(NS)) bus ();

   sprite_engine_ctrl #(.NUM_SPRITES(NS), .H_ACTIVE(640), .V_ACTIVE(480)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // ROM content model: {red, green, blue} for a line/column
   function automatic logic [2:0] rom_pix(input logic [3:0] l, input logic [3:0] c);
      return {~(l[0] ^ c[0]), l[3] ^ c[3], l[1] | c[2]};
   endfunction

   assign {bus.rom_red, bus.rom_green, bus.rom_blue} = rom_pix(bus.rom_line, bus.rom_column);

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cfg(input int i, input bit en, input logic [9:0] cx, input logic [9:0] cy,
                      input logic [3:0] cvx, input logic [3:0] cvy);
      @(negedge clk);
      bus.cfg_we    = 1'b1;
      bus.cfg_index = 2'(i);
      bus.cfg_en    = en;
      bus.cfg_x     = cx;
      bus.cfg_y     = cy;
      bus.cfg_vx    = cvx;
      bus.cfg_vy    = cvy;
      @(negedge clk);
      bus.cfg_we    = 1'b0;
   endtask

   task automatic beam(input string tag, input logic [9:0] bx, input logic [9:0] by, input bit act,
                       input bit eh, input logic [3:0] el, input logic [3:0] ec);
      exp_t e;
      e.hit   = eh;
      e.valid = act;
      e.line  = eh ? el : 4'd0;
      e.col   = eh ? ec : 4'd0;
      e.rgb   = eh ? rom_pix(el, ec) : 3'd0;
      sb.push_back(e);
      @(negedge clk);
      bus.x      = bx;
      bus.y      = by;
      bus.active = act;
      @(posedge clk);
      #1;
      chk({tag, ".line"}, 16'(bus.rom_line), 16'(sb[0].line));
      chk({tag, ".col"}, 16'(bus.rom_column), 16'(sb[0].col));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, ".hit"}, 16'(bus.pixel_hit), 16'(e.hit));
      chk({tag, ".valid"}, 16'(bus.pixel_valid), 16'(e.valid));
      chk({tag, ".rgb"}, 16'({bus.pixel_red, bus.pixel_green, bus.pixel_blue}), 16'(e.rgb));
      @(negedge clk);
      bus.active = 1'b0;
   endtask

   // One frame: pulse frame_start and count busy cycles over a fixed window
   task automatic frame(input string tag, input bit double_pulse, input bit collide);
      int cnt;
      cnt = 0;
      @(negedge clk);
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (bus.busy === 1'b1) cnt++;
         if (c == 1 && double_pulse) bus.frame_start = 1'b1;
         if (c == 1 && collide) begin
            bus.cfg_we    = 1'b1;
            bus.cfg_index = 2'd1;
            bus.cfg_en    = 1'b1;
            bus.cfg_x     = 10'd300;
            bus.cfg_y     = 10'd200;
            bus.cfg_vx    = 4'd2;
            bus.cfg_vy    = 4'd0;
         end
         if (c == 2) begin
            bus.frame_start = 1'b0;
            bus.cfg_we      = 1'b0;
         end
         @(negedge clk);
      end
      chk({tag, ".busy_cycles"}, 16'(cnt), 16'(NS));
      chk({tag, ".busy_after"}, 16'(bus.busy), 16'd0);
   endtask

   initial begin
      bus.frame_start = 1'b0;
      bus.active      = 1'b1;
      bus.x           = 10'd100;
      bus.y           = 10'd50;
      bus.cfg_we      = 1'b0;
      bus.cfg_index   = '0;
      bus.cfg_en      = 1'b0;
      bus.cfg_x       = '0;
      bus.cfg_y       = '0;
      bus.cfg_vx      = '0;
      bus.cfg_vy      = '0;

      // reset held 3 cycles with the beam active
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.line", 16'(bus.rom_line), 16'd0);
      chk("rst.col", 16'(bus.rom_column), 16'd0);
      chk("rst.rgb", 16'({bus.pixel_red, bus.pixel_green, bus.pixel_blue}), 16'd0);
      chk("rst.hit", 16'(bus.pixel_hit), 16'd0);
      chk("rst.valid", 16'(bus.pixel_valid), 16'd0);
      chk("rst.busy", 16'(bus.busy), 16'd0);
      reset      = 1'b0;
      bus.active = 1'b0;
      beam("rst.nohit0", 10'd0, 10'd0, 1'b1, 1'b0, 4'd0, 4'd0);
      beam("rst.nohit1", 10'd100, 10'd50, 1'b1, 1'b0, 4'd0, 4'd0);

      // single sprite at (100,50)
      cfg(0, 1'b1, 10'd100, 10'd50, 4'd0, 4'd0);
      beam("s.tl", 10'd100, 10'd50, 1'b1, 1'b1, 4'd0, 4'd0);
      beam("s.br", 10'd115, 10'd65, 1'b1, 1'b1, 4'd15, 4'd15);
      beam("s.mid", 10'd107, 10'd53, 1'b1, 1'b1, 4'd3, 4'd7);
      beam("s.right", 10'd116, 10'd50, 1'b1, 1'b0, 4'd0, 4'd0);
      beam("s.below", 10'd100, 10'd66, 1'b1, 1'b0, 4'd0, 4'd0);
      beam("s.left", 10'd99, 10'd50, 1'b1, 1'b0, 4'd0, 4'd0);
      beam("s.inact", 10'd100, 10'd50, 1'b0, 1'b0, 4'd0, 4'd0);

      // priority between overlapping sprites 0 and 1
      cfg(0, 1'b1, 10'd200, 10'd100, 4'd0, 4'd0);
      cfg(1, 1'b1, 10'd208, 10'd100, 4'd0, 4'd0);
      beam("p.overlap", 10'd210, 10'd100, 1'b1, 1'b1, 4'd0, 4'd10);
      beam("p.only1", 10'd220, 10'd100, 1'b1, 1'b1, 4'd0, 4'd12);

      // bounce and saturation, with a second frame_start inside the update window
      cfg(0, 1'b1, 10'd620, 10'd462, 4'd5, 4'd7);
      cfg(1, 1'b1, 10'd2, 10'd200, 4'hD, 4'd0);
      cfg(2, 1'b1, 10'd4, 10'd300, 4'h8, 4'd0);
      cfg(3, 1'b0, 10'd0, 10'd0, 4'd0, 4'd0);
      frame("f1", 1'b1, 1'b0);
      beam("f1.s0", 10'd624, 10'd464, 1'b1, 1'b1, 4'd0, 4'd0);
      beam("f1.s0left", 10'd623, 10'd464, 1'b1, 1'b0, 4'd0, 4'd0);
      beam("f1.s1", 10'd0, 10'd200, 1'b1, 1'b1, 4'd0, 4'd0);
      beam("f1.s1br", 10'd15, 10'd215, 1'b1, 1'b1, 4'd15, 4'd15);
      beam("f1.s2", 10'd0, 10'd300, 1'b1, 1'b1, 4'd0, 4'd0);
      frame("f2", 1'b0, 1'b0);
      beam("f2.s0", 10'd619, 10'd457, 1'b1, 1'b1, 4'd0, 4'd0);
      beam("f2.s0left", 10'd618, 10'd457, 1'b1, 1'b0, 4'd0, 4'd0);
      beam("f2.s1", 10'd3, 10'd200, 1'b1, 1'b1, 4'd0, 4'd0);
      beam("f2.s1left", 10'd2, 10'd200, 1'b1, 1'b0, 4'd0, 4'd0);
      beam("f2.s2", 10'd7, 10'd300, 1'b1, 1'b1, 4'd0, 4'd0);
      beam("f2.s2left", 10'd6, 10'd300, 1'b1, 1'b0, 4'd0, 4'd0);

      // config write to sprite 1 on its own update cycle
      cfg(3, 1'b1, 10'd400, 10'd400, 4'd1, 4'hF);
      frame("f3", 1'b0, 1'b1);
      beam("f3.s1", 10'd300, 10'd200, 1'b1, 1'b1, 4'd0, 4'd0);
      beam("f3.s1c2", 10'd302, 10'd200, 1'b1, 1'b1, 4'd0, 4'd2);
      beam("f3.s0", 10'd614, 10'd450, 1'b1, 1'b1, 4'd0, 4'd0);
      beam("f3.s0above", 10'd614, 10'd449, 1'b1, 1'b0, 4'd0, 4'd0);
      beam("f3.s2", 10'd14, 10'd300, 1'b1, 1'b1, 4'd0, 4'd0);
      beam("f3.s2left", 10'd13, 10'd300, 1'b1, 1'b0, 4'd0, 4'd0);
      beam("f3.s3", 10'd401, 10'd399, 1'b1, 1'b1, 4'd0, 4'd0);
      beam("f3.s3left", 10'd400, 10'd399, 1'b1, 1'b0, 4'd0, 4'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
